// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the LSU (port 0) and a debug/DMA
// master (port 1). Define DMEM_ARB_TIMEOUT_EN to add a watchdog that aborts stuck BUSY cycles.
module dmem_port_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_i,
    input  logic [XLEN-1:0]   adr0_i,
    input  logic              we0_i,
    input  logic [XLEN/8-1:0] be0_i,
    input  logic [XLEN-1:0]   d0_i,
    output logic              ack0_o,
    output logic              err0_o,
    output logic [XLEN-1:0]   q0_o,
    input  logic              req1_i,
    input  logic [XLEN-1:0]   adr1_i,
    input  logic              we1_i,
    input  logic [XLEN/8-1:0] be1_i,
    input  logic [XLEN-1:0]   d1_i,
    output logic              ack1_o,
    output logic              err1_o,
    output logic [XLEN-1:0]   q1_o,
    output logic              mem_req_o,
    output logic [XLEN-1:0]   mem_adr_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_d_o,
    input  logic              mem_ack_i,
    input  logic              mem_err_i,
    input  logic [XLEN-1:0]   mem_q_i,
    output logic [1:0]        grant_o
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [1:0]        grant_q, grant_d;
    logic [XLEN-1:0]   adr_q, adr_d;
    logic              we_q, we_d;
    logic [XLEN/8-1:0] be_q, be_d;
    logic [XLEN-1:0]   d_q, d_d;
    logic              any_req, pick1, resp, timeout_hit, done;

    assign any_req = req0_i | req1_i;
    // Port 1 wins when it is the only requester or when the pointer favours it.
    assign pick1   = req1_i & (~req0_i | ptr_q);
    assign resp    = (state_q == BUSY) & (mem_ack_i | mem_err_i);
    assign done    = resp | timeout_hit;

`ifdef DMEM_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    assign cnt_d       = (state_q == BUSY) ? cnt_q + 8'd1 : 8'd0;
    assign timeout_hit = (state_q == BUSY) & ~mem_ack_i & ~mem_err_i & (cnt_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 8'd0;
        else     cnt_q <= cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            grant_q <= 2'b00;
            adr_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            d_q     <= d_d;
        end
    end

    // NOTE: every signal written here gets a hold default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        adr_d   = adr_q;
        we_d    = we_q;
        be_d    = be_q;
        d_d     = d_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = BUSY;
                    grant_d = pick1 ? 2'b10 : 2'b01;
                    adr_d   = pick1 ? adr1_i : adr0_i;
                    we_d    = pick1 ? we1_i  : we0_i;
                    be_d    = pick1 ? be1_i  : be0_i;
                    d_d     = pick1 ? d1_i   : d0_i;
                end
            end
            BUSY: begin
                if (done) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    ptr_d   = grant_q[0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_o = (state_q == BUSY) & ~timeout_hit;
        ack0_o    = 1'b0;
        err0_o    = 1'b0;
        q0_o      = '0;
        ack1_o    = 1'b0;
        err1_o    = 1'b0;
        q1_o      = '0;
        if (state_q == BUSY) begin
            // An error response suppresses a simultaneous ack.
            ack0_o = grant_q[0] & mem_ack_i & ~mem_err_i;
            err0_o = grant_q[0] & (mem_err_i | timeout_hit);
            q0_o   = (grant_q[0] & resp) ? mem_q_i : '0;
            ack1_o = grant_q[1] & mem_ack_i & ~mem_err_i;
            err1_o = grant_q[1] & (mem_err_i | timeout_hit);
            q1_o   = (grant_q[1] & resp) ? mem_q_i : '0;
        end
    end

    assign grant_o   = grant_q;
    assign mem_adr_o = adr_q;
    assign mem_we_o  = we_q;
    assign mem_be_o  = be_q;
    assign mem_d_o   = d_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter; the watchdog scenario runs when DMEM_ARB_TIMEOUT_EN is defined.
module tb_dmem_port_arbiter;
    localparam int XLEN = 32;
    localparam int BW   = XLEN / 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0_i, we0_i, req1_i, we1_i;
    logic [XLEN-1:0] adr0_i, d0_i, adr1_i, d1_i;
    logic [BW-1:0]   be0_i, be1_i;
    logic            ack0_o, err0_o, ack1_o, err1_o;
    logic [XLEN-1:0] q0_o, q1_o;
    logic            mem_req_o, mem_we_o, mem_ack_i, mem_err_i;
    logic [XLEN-1:0] mem_adr_o, mem_d_o, mem_q_i;
    logic [BW-1:0]   mem_be_o;
    logic [1:0]      grant_o;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.XLEN(XLEN), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .req0_i(req0_i), .adr0_i(adr0_i), .we0_i(we0_i), .be0_i(be0_i), .d0_i(d0_i),
        .ack0_o(ack0_o), .err0_o(err0_o), .q0_o(q0_o),
        .req1_i(req1_i), .adr1_i(adr1_i), .we1_i(we1_i), .be1_i(be1_i), .d1_i(d1_i),
        .ack1_o(ack1_o), .err1_o(err1_o), .q1_o(q1_o),
        .mem_req_o(mem_req_o), .mem_adr_o(mem_adr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_d_o(mem_d_o),
        .mem_ack_i(mem_ack_i), .mem_err_i(mem_err_i), .mem_q_i(mem_q_i),
        .grant_o(grant_o)
    );

    typedef struct packed {
        logic [1:0]      grant;
        logic [XLEN-1:0] adr;
        logic            we;
        logic [BW-1:0]   be;
        logic [XLEN-1:0] d;
    } req_t;

    typedef struct packed {
        logic            ack0;
        logic            err0;
        logic [XLEN-1:0] q0;
        logic            ack1;
        logic            err1;
        logic [XLEN-1:0] q1;
    } rsp_t;

    req_t req_sb[$];
    rsp_t rsp_sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected bus request, taken from the payload this bench is driving on the winning port.
    task automatic push_req(input logic [1:0] g);
        req_t e;
        if (g == 2'b01) e = '{g, adr0_i, we0_i, be0_i, d0_i};
        else            e = '{g, adr1_i, we1_i, be1_i, d1_i};
        req_sb.push_back(e);
    endtask

    // Expected port responses; owner 2'b00 means no port may see anything.
    task automatic push_rsp(input logic [1:0] owner, input logic ack, input logic err,
                            input logic to, input logic [XLEN-1:0] q);
        rsp_t e;
        e.ack0 = owner[0] & ack & ~err;
        e.err0 = owner[0] & (err | to);
        e.q0   = (owner[0] & (ack | err)) ? q : '0;
        e.ack1 = owner[1] & ack & ~err;
        e.err1 = owner[1] & (err | to);
        e.q1   = (owner[1] & (ack | err)) ? q : '0;
        rsp_sb.push_back(e);
    endtask

    task automatic wait_grant(output int n, output req_t got);
        n = 0;
        do begin
            step();
            n++;
        end while (!mem_req_o && n < 4);
        got = '{grant_o, mem_adr_o, mem_we_o, mem_be_o, mem_d_o};
    endtask

    task automatic drive_rsp(input logic ack, input logic err, input logic [XLEN-1:0] q,
                             output rsp_t got);
        mem_ack_i = ack;
        mem_err_i = err;
        mem_q_i   = q;
        #1;
        got = '{ack0_o, err0_o, q0_o, ack1_o, err1_o, q1_o};
    endtask

    task automatic end_rsp();
        step();
        mem_ack_i = 1'b0;
        mem_err_i = 1'b0;
        mem_q_i   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_req_o, mem_adr_o, mem_we_o, mem_be_o, mem_d_o, grant_o,
             ack0_o, err0_o, q0_o, ack1_o, err1_o, q1_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b adr=%h we=%b be=%h d=%h grant=%b ack0=%b err0=%b ack1=%b err1=%b, expected all zero",
                     mem_req_o, mem_adr_o, mem_we_o, mem_be_o, mem_d_o, grant_o, ack0_o, err0_o, ack1_o, err1_o);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        int n; req_t got_req, e_req; rsp_t got_rsp, e_rsp;
        req0_i = 1'b1; adr0_i = 32'h200; we0_i = 1'b0; be0_i = 4'hF; d0_i = '0;
        push_req(2'b01);
        wait_grant(n, got_req);
        e_req = req_sb.pop_front();
        checks++;
        if (n != 1 || got_req !== e_req) begin
            errors++;
            $display("FAIL read_grant: latency %0d bus %h, expected latency 1 bus %h", n, got_req, e_req);
        end
        push_rsp(2'b01, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
        drive_rsp(1'b1, 1'b0, 32'hDEADBEEF, got_rsp);
        e_rsp = rsp_sb.pop_front();
        checks++;
        if (got_rsp !== e_rsp) begin
            errors++;
            $display("FAIL read_ack: got %h expected %h", got_rsp, e_rsp);
        end
        req0_i = 1'b0;
        end_rsp();
        checks++;
        if ({mem_req_o, grant_o} !== 3'b000) begin
            errors++;
            $display("FAIL read_release: req=%b grant=%b, expected 0 00", mem_req_o, grant_o);
        end
        // A stray response while idle must not reach either port.
        push_rsp(2'b00, 1'b1, 1'b0, 1'b0, 32'h5555_AAAA);
        drive_rsp(1'b1, 1'b0, 32'h5555_AAAA, got_rsp);
        e_rsp = rsp_sb.pop_front();
        checks++;
        if (got_rsp !== e_rsp) begin
            errors++;
            $display("FAIL idle_ack_ignored: got %h expected %h", got_rsp, e_rsp);
        end
        end_rsp();
    endtask

    task automatic test_round_robin();
        int n; req_t got_req, e_req; rsp_t got_rsp, e_rsp;
        logic [1:0] order [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        rst = 1'b1;
        step();
        rst = 1'b0;
        adr0_i = 32'h100; we0_i = 1'b0; be0_i = 4'hF; d0_i = '0;
        adr1_i = 32'h300; we1_i = 1'b0; be1_i = 4'hF; d1_i = '0;
        req0_i = 1'b1;
        req1_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_req(order[i]);
            wait_grant(n, got_req);
            e_req = req_sb.pop_front();
            checks++;
            if (n != 1 || got_req !== e_req) begin
                errors++;
                $display("FAIL rr_grant%0d: latency %0d bus %h, expected latency 1 bus %h", i, n, got_req, e_req);
            end
            push_rsp(order[i], 1'b1, 1'b0, 1'b0, 32'hA000_0000 + i);
            drive_rsp(1'b1, 1'b0, 32'hA000_0000 + i, got_rsp);
            e_rsp = rsp_sb.pop_front();
            checks++;
            if (got_rsp !== e_rsp) begin
                errors++;
                $display("FAIL rr_ack%0d: got %h expected %h", i, got_rsp, e_rsp);
            end
            if (i == 3) begin
                req0_i = 1'b0;
                req1_i = 1'b0;
            end
            end_rsp();
            checks++;
            if ({mem_req_o, grant_o} !== 3'b000) begin
                errors++;
                $display("FAIL rr_bubble%0d: req=%b grant=%b, expected 0 00", i, mem_req_o, grant_o);
            end
        end
    endtask

    task automatic test_write_err();
        int n; req_t got_req, e_req; rsp_t got_rsp, e_rsp;
        req1_i = 1'b1; adr1_i = 32'h80; we1_i = 1'b1; be1_i = 4'hF; d1_i = 32'h12345678;
        push_req(2'b10);
        wait_grant(n, got_req);
        e_req = req_sb.pop_front();
        checks++;
        if (n != 1 || got_req !== e_req) begin
            errors++;
            $display("FAIL write_grant: latency %0d bus %h, expected latency 1 bus %h", n, got_req, e_req);
        end
        push_rsp(2'b10, 1'b0, 1'b1, 1'b0, 32'h0BAD_0BAD);
        drive_rsp(1'b0, 1'b1, 32'h0BAD_0BAD, got_rsp);
        e_rsp = rsp_sb.pop_front();
        checks++;
        if (got_rsp !== e_rsp) begin
            errors++;
            $display("FAIL write_err: got %h expected %h", got_rsp, e_rsp);
        end
        req1_i = 1'b0;
        end_rsp();
    endtask

    task automatic test_drop_req();
        int n; req_t got_req, e_req; rsp_t got_rsp, e_rsp;
        req1_i = 1'b1; adr1_i = 32'h10; we1_i = 1'b0; be1_i = 4'h1; d1_i = '0;
        push_req(2'b10);
        wait_grant(n, got_req);
        e_req = req_sb.pop_front();
        checks++;
        if (n != 1 || got_req !== e_req) begin
            errors++;
            $display("FAIL drop_grant: latency %0d bus %h, expected latency 1 bus %h", n, got_req, e_req);
        end
        req1_i = 1'b0;
        step();
        push_rsp(2'b10, 1'b1, 1'b0, 1'b0, 32'h0000_7777);
        drive_rsp(1'b1, 1'b0, 32'h0000_7777, got_rsp);
        e_rsp = rsp_sb.pop_front();
        checks++;
        if (got_rsp !== e_rsp) begin
            errors++;
            $display("FAIL drop_ack: got %h expected %h", got_rsp, e_rsp);
        end
        end_rsp();
    endtask

    task automatic test_ack_err_collision();
        int n; req_t got_req, e_req; rsp_t got_rsp, e_rsp;
        req0_i = 1'b1; adr0_i = 32'h44; we0_i = 1'b1; be0_i = 4'h3; d0_i = 32'hCAFEF00D;
        push_req(2'b01);
        wait_grant(n, got_req);
        e_req = req_sb.pop_front();
        checks++;
        if (n != 1 || got_req !== e_req) begin
            errors++;
            $display("FAIL collide_grant: latency %0d bus %h, expected latency 1 bus %h", n, got_req, e_req);
        end
        push_rsp(2'b01, 1'b1, 1'b1, 1'b0, 32'h1111_2222);
        drive_rsp(1'b1, 1'b1, 32'h1111_2222, got_rsp);
        e_rsp = rsp_sb.pop_front();
        checks++;
        if (got_rsp !== e_rsp) begin
            errors++;
            $display("FAIL ack_err_collide: got %h expected %h", got_rsp, e_rsp);
        end
        req0_i = 1'b0;
        end_rsp();
    endtask

    // The previous winner was port 0, so only a reset pointer lets port 0 win again here.
    task automatic test_reset_mid();
        int n; req_t got_req, e_req; rsp_t got_rsp, e_rsp;
        req1_i = 1'b1; adr1_i = 32'h900; we1_i = 1'b0; be1_i = 4'hF; d1_i = '0;
        push_req(2'b10);
        wait_grant(n, got_req);
        e_req = req_sb.pop_front();
        checks++;
        if (n != 1 || got_req !== e_req) begin
            errors++;
            $display("FAIL mid_grant: latency %0d bus %h, expected latency 1 bus %h", n, got_req, e_req);
        end
        rst = 1'b1;
        push_rsp(2'b00, 1'b1, 1'b0, 1'b0, 32'h3333_4444);
        drive_rsp(1'b1, 1'b0, 32'h3333_4444, got_rsp);
        e_rsp = rsp_sb.pop_front();
        checks++;
        if ({mem_req_o, grant_o} !== 3'b000 || got_rsp !== e_rsp) begin
            errors++;
            $display("FAIL reset_mid: req=%b grant=%b rsp %h, expected 0 00 rsp %h", mem_req_o, grant_o, got_rsp, e_rsp);
        end
        end_rsp();
        req0_i = 1'b1; adr0_i = 32'h500; we0_i = 1'b0; be0_i = 4'hF; d0_i = '0;
        rst = 1'b0;
        push_req(2'b01);
        wait_grant(n, got_req);
        e_req = req_sb.pop_front();
        checks++;
        if (n != 1 || got_req !== e_req) begin
            errors++;
            $display("FAIL post_reset_grant: latency %0d bus %h, expected latency 1 bus %h", n, got_req, e_req);
        end
        req1_i = 1'b0;
        push_rsp(2'b01, 1'b1, 1'b0, 1'b0, 32'h0);
        drive_rsp(1'b1, 1'b0, 32'h0, got_rsp);
        e_rsp = rsp_sb.pop_front();
        checks++;
        if (got_rsp !== e_rsp) begin
            errors++;
            $display("FAIL post_reset_ack: got %h expected %h", got_rsp, e_rsp);
        end
        req0_i = 1'b0;
        end_rsp();
    endtask

`ifdef DMEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n; req_t got_req, e_req; rsp_t got_rsp, e_rsp;
        req0_i = 1'b1; adr0_i = 32'h600; we0_i = 1'b0; be0_i = 4'hF; d0_i = '0;
        push_req(2'b01);
        wait_grant(n, got_req);
        e_req = req_sb.pop_front();
        checks++;
        if (n != 1 || got_req !== e_req) begin
            errors++;
            $display("FAIL timeout_grant: latency %0d bus %h, expected latency 1 bus %h", n, got_req, e_req);
        end
        for (int k = 1; k <= 15; k++) begin
            if (k > 1) step();
            push_rsp(2'b01, 1'b0, 1'b0, k == 15, 32'h0);
            drive_rsp(1'b0, 1'b0, 32'h0, got_rsp);
            e_rsp = rsp_sb.pop_front();
            checks++;
            if (got_rsp !== e_rsp) begin
                errors++;
                $display("FAIL timeout_cycle%0d: got %h expected %h", k, got_rsp, e_rsp);
            end
        end
        req0_i = 1'b0;
        end_rsp();
        push_rsp(2'b00, 1'b1, 1'b0, 1'b0, 32'h9999_0000);
        drive_rsp(1'b1, 1'b0, 32'h9999_0000, got_rsp);
        e_rsp = rsp_sb.pop_front();
        checks++;
        if ({mem_req_o, grant_o} !== 3'b000 || got_rsp !== e_rsp) begin
            errors++;
            $display("FAIL late_ack: req=%b grant=%b rsp %h, expected 0 00 rsp %h", mem_req_o, grant_o, got_rsp, e_rsp);
        end
        end_rsp();
    endtask
`else
    task automatic test_no_timeout();
        int n; req_t got_req, e_req; rsp_t got_rsp, e_rsp;
        req0_i = 1'b1; adr0_i = 32'h600; we0_i = 1'b0; be0_i = 4'hF; d0_i = '0;
        push_req(2'b01);
        wait_grant(n, got_req);
        e_req = req_sb.pop_front();
        checks++;
        if (n != 1 || got_req !== e_req) begin
            errors++;
            $display("FAIL hold_grant: latency %0d bus %h, expected latency 1 bus %h", n, got_req, e_req);
        end
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) step();
            push_rsp(2'b01, 1'b0, 1'b0, 1'b0, 32'h0);
            drive_rsp(1'b0, 1'b0, 32'h0, got_rsp);
            e_rsp = rsp_sb.pop_front();
            checks++;
            if (got_rsp !== e_rsp || {mem_req_o, grant_o} !== 3'b101) begin
                errors++;
                $display("FAIL hold_cycle%0d: rsp %h req=%b grant=%b, expected rsp %h req=1 grant=01",
                         k, got_rsp, mem_req_o, grant_o, e_rsp);
            end
        end
        push_rsp(2'b01, 1'b1, 1'b0, 1'b0, 32'h0F0F_0F0F);
        drive_rsp(1'b1, 1'b0, 32'h0F0F_0F0F, got_rsp);
        e_rsp = rsp_sb.pop_front();
        checks++;
        if (got_rsp !== e_rsp) begin
            errors++;
            $display("FAIL hold_ack: got %h expected %h", got_rsp, e_rsp);
        end
        req0_i = 1'b0;
        end_rsp();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req0_i = 1'b0; adr0_i = '0; we0_i = 1'b0; be0_i = '0; d0_i = '0;
        req1_i = 1'b0; adr1_i = '0; we1_i = 1'b0; be1_i = '0; d1_i = '0;
        mem_ack_i = 1'b0; mem_err_i = 1'b0; mem_q_i = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_err();
        test_drop_req();
        test_ack_err_collision();
        test_reset_mid();
`ifdef DMEM_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Arbitrates one data-memory port between two requesters: the core LSU (port 0) and a debug/DMA master (port 1).
- Sits between the ex/mem load-store path and the AHB3-Lite data bridge.
- Round-robin grant; one outstanding transaction at a time.
- Forwards the memory response to the granted requester only.

Parameters:
XLEN, 32, address/data width
TIMEOUT, 15, cycles a granted transaction may stay in BUSY before abort (used only with optional feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req0_i  in  1  LSU request; held with its payload stable until ack0_o or err0_o
adr0_i  in  XLEN  LSU address
we0_i  in  1  LSU write enable
be0_i  in  XLEN/8  LSU byte enables
d0_i  in  XLEN  LSU write data
ack0_o  out  1  LSU completion pulse
err0_o  out  1  LSU error pulse
q0_o  out  XLEN  LSU read data, valid with ack0_o
req1_i, adr1_i, we1_i, be1_i, d1_i, ack1_o, err1_o, q1_o  same as port 0, for debug/DMA
mem_req_o  out  1  request to the bus bridge
mem_adr_o  out  XLEN  latched address
mem_we_o  out  1  latched write enable
mem_be_o  out  XLEN/8  latched byte enables
mem_d_o  out  XLEN  latched write data
mem_ack_i  in  1  bridge completion
mem_err_i  in  1  bridge error
mem_q_i  in  XLEN  bridge read data
grant_o  out  2  one-hot current owner; 00 when idle

Behaviour:
- Reset values (asynchronous, any time): state=IDLE, pointer=0, and mem_req_o, mem_adr_o, mem_we_o, mem_be_o, mem_d_o, grant_o, ack*/err* all 0.
- Reset mid-transaction: the transaction is dropped silently; no ack or err is issued.
- FSM states: IDLE, BUSY.
- IDLE, no request: stay in IDLE.
- IDLE, one request: grant that port.
- IDLE, both requests: grant the port selected by pointer (0 -> port 0, 1 -> port 1).
- IDLE -> BUSY on a grant:
  - register the winner's adr/we/be/d into the mem_* outputs;
  - set grant_o one-hot and mem_req_o=1;
  - all take effect the cycle after req is first sampled.
- BUSY: mem_* outputs and grant_o are held constant.
- BUSY, mem_ack_i or mem_err_i high:
  - same cycle, combinationally forward ack/err and mem_q_i to the granted port;
  - the other port sees ack=err=0 and q=0.
  - Next cycle: state=IDLE, mem_req_o=0, grant_o=00, pointer = non-winner.
- Simultaneous mem_ack_i and mem_err_i: err wins; ack is suppressed.
- Responses in IDLE are ignored (no pulse).
- Minimum latency:
  - req seen at cycle N -> mem_req_o at N+1 -> earliest ack at N+1;
  - re-arbitration at N+2 (one idle bubble between transactions).
- Requester keeping req high after its ack starts a new transaction. The pointer guarantees the other port wins if it is waiting; no starvation.
- Requester dropping req while BUSY (protocol violation): the transaction still completes and the ack is still pulsed.
- be width is XLEN/8. No address alignment checking in this block.

Optional Feature:
- Macro: DMEM_ARB_TIMEOUT_EN.
- When defined:
  - an 8-bit counter clears on entering BUSY and increments each BUSY cycle without a response;
  - on reaching TIMEOUT: pulse err to the owner, drop mem_req_o, go to IDLE next cycle, advance the pointer;
  - a late mem_ack_i/mem_err_i arriving in IDLE is ignored.
- When not defined: no counter; BUSY waits indefinitely.

Test Plan:
- Only req0_i=1, adr0_i=0x200, we0_i=0 -> mem_req_o=1 and mem_adr_o=0x200 one cycle later, grant_o=01; mem_ack_i with mem_q_i=0xDEADBEEF -> ack0_o=1 and q0_o=0xDEADBEEF same cycle; q1_o=0.
- req0_i and req1_i both held high after reset -> grant order 01, 10, 01, 10; each grant separated by one idle cycle.
- Port 1 write d1_i=0x12345678, be1_i=0xF -> mem_we_o=1, mem_d_o=0x12345678, mem_be_o=0xF; mem_err_i=1 -> err1_o=1, ack1_o=0.
- mem_ack_i and mem_err_i high together in BUSY -> err=1, ack=0 on the owner port.
- rst pulsed while BUSY -> mem_req_o=0 and grant_o=00 immediately; no ack on either port; next grant after release goes to port 0 when both request.
- With DMEM_ARB_TIMEOUT_EN, TIMEOUT=15, bridge never responds -> err0_o pulses on the 15th BUSY cycle; a later mem_ack_i produces no ack.
